// File: rtl/serial_byte_deserializer.sv
// Framed serial bits -> {swap,byte} FIFO entries; entry visible 1 cycle after the frame's last bit.
// Backpressure: out_ready stalls the FIFO head; a good frame arriving at a full FIFO (no pop) is dropped with overflow.
module serial_byte_deserializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin_valid,
    input  logic       sin_bit,
    input  logic       frame_start,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] data_out,
    output logic       swap_out,
    output logic       parity_err,
    output logic       overflow,
    output logic       frame_abort
);

    localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, SWAP, PAR} state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          swap_q, swap_d;

    logic          start, abort, shift_en, swap_en, frame_done, done_swap, par_ok;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [8:0]    hold_q;
    logic [8:0]    head;
    logic          push, pop, full;

    logic          parity_err_q, overflow_q, frame_abort_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sin_valid) begin
            if (frame_start) begin
                state_d = DATA;
            end else begin
                case (state_q)
                    DATA:    if (bit_cnt_q == 4'd7) state_d = SWAP;
                    SWAP:    state_d = (PARITY_EN != 0) ? PAR : IDLE;
                    PAR:     state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // A frame_start always wins: it either opens a frame or aborts the one in flight.
    always_comb begin
        start      = sin_valid & frame_start;
        abort      = start & (state_q != IDLE);
        shift_en   = sin_valid & ~frame_start & (state_q == DATA);
        swap_en    = sin_valid & ~frame_start & (state_q == SWAP);
        frame_done = sin_valid & ~frame_start &
                     (((state_q == SWAP) && (PARITY_EN == 0)) || (state_q == PAR));
        done_swap  = (state_q == PAR) ? swap_q : sin_bit;
        par_ok     = (state_q != PAR) || !(^{shift_q, swap_q, sin_bit});
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        swap_d    = swap_q;
        if (start) begin
            shift_d   = {7'b0, sin_bit};
            bit_cnt_d = 4'd1;
        end else if (shift_en) begin
            shift_d   = {shift_q[6:0], sin_bit};
            bit_cnt_d = bit_cnt_q + 4'd1;
        end
        if (swap_en) begin
            swap_d = sin_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            swap_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            swap_q    <= swap_d;
        end
    end

    assign full      = (count_q == FULL_CNT);
    assign out_valid = (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign pop       = out_valid & out_ready;
    assign push      = frame_done & par_ok & (~full | pop);

    // When empty, show the last entry that left the FIFO rather than a stale slot.
    assign data_out  = out_valid ? head[7:0] : hold_q[7:0];
    assign swap_out  = out_valid ? head[8]   : hold_q[8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {done_swap, shift_q};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                hold_q   <= head;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q  <= 1'b0;
            overflow_q    <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            parity_err_q  <= frame_done & ~par_ok;
            overflow_q    <= frame_done & par_ok & full & ~pop;
            frame_abort_q <= abort;
        end
    end

    assign parity_err  = parity_err_q;
    assign overflow    = overflow_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_serial_byte_deserializer.sv
// Directed frames with a scoreboard queue; a negedge monitor pops and compares every accepted output.
module tb_serial_byte_deserializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sin_valid = 1'b0;
    logic       sin_bit = 1'b0;
    logic       frame_start = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [7:0] data_out;
    logic       swap_out;
    logic       parity_err;
    logic       overflow;
    logic       frame_abort;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    int         perr_cnt = 0, ovf_cnt = 0, abt_cnt = 0;
    int         exp_perr = 0, exp_ovf = 0, exp_abt = 0;

    serial_byte_deserializer #(.FIFO_DEPTH(4), .PARITY_EN(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sin_valid   (sin_valid),
        .sin_bit     (sin_bit),
        .frame_start (frame_start),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .swap_out    (swap_out),
        .parity_err  (parity_err),
        .overflow    (overflow),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic even_par(input logic [7:0] d, input logic s);
        return ^{d, s};
    endfunction

    task automatic drive_bit(input logic v, input logic b, input logic fs);
        sin_valid   = v;
        sin_bit     = b;
        frame_start = fs;
        @(posedge clk);
        #1;
        sin_valid   = 1'b0;
        frame_start = 1'b0;
        sin_bit     = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic sw, input logic par);
        for (int i = 7; i >= 0; i--) begin
            drive_bit(1'b1, d[i], (i == 7));
        end
        drive_bit(1'b1, sw, 1'b0);
        drive_bit(1'b1, par, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (parity_err)  perr_cnt++;
            if (overflow)    ovf_cnt++;
            if (frame_abort) abt_cnt++;
            if (parity_err || overflow || frame_abort) begin
                check("pulse_exclusive", 32'(parity_err) + 32'(overflow) + 32'(frame_abort), 32'd1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h, expected no output", {swap_out, data_out});
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("out_data", 32'(data_out), 32'(e[7:0]));
                    check("out_swap", 32'(swap_out), 32'(e[8]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         gaps[10] = '{0, 2, 0, 1, 3, 0, 0, 1, 2, 1};
        logic [9:0] fr;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data",  32'(data_out),  32'd0);
        check("rst_swap",  32'(swap_out),  32'd0);
        check("rst_pulses", 32'({parity_err, overflow, frame_abort}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: good frame A5/swap 1, visible one cycle after the parity bit
        out_ready = 1'b1;
        exp_q.push_back({1'b1, 8'hA5});
        send_frame(8'hA5, 1'b1, 1'b1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data",  32'(data_out),  32'hA5);
        repeat (3) @(posedge clk);
        #1;
        check("t1_perr", 32'(perr_cnt), 32'(exp_perr));

        // 2: same frame, bad parity
        send_frame(8'hA5, 1'b1, 1'b0);
        exp_perr = 1;
        check("t2_valid", 32'(out_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t2_valid_late", 32'(out_valid), 32'd0);
        check("t2_perr", 32'(perr_cnt), 32'(exp_perr));

        // 3: five back-to-back frames into a depth-4 FIFO while stalled
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) exp_q.push_back({1'b0, 8'(k)});
            send_frame(8'(k), 1'b0, even_par(8'(k), 1'b0));
        end
        exp_ovf = 1;
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_head",  32'(data_out),  32'h01);
        repeat (3) @(posedge clk);
        #1;
        check("t3_head_stable", 32'(data_out), 32'h01);
        check("t3_ovf", 32'(ovf_cnt), 32'(exp_ovf));
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t3_empty",     32'(out_valid),   32'd0);
        check("t3_hold_last", 32'(data_out),    32'h04);
        check("t3_drained",   32'(exp_q.size()), 32'd0);

        // 4: four bits of a frame, then a fresh frame_start with 3C
        drive_bit(1'b1, 1'b1, 1'b1);
        drive_bit(1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0);
        exp_q.push_back({1'b0, 8'h3C});
        send_frame(8'h3C, 1'b0, 1'b0);
        exp_abt = 1;
        repeat (4) @(posedge clk);
        #1;
        check("t4_abort",   32'(abt_cnt),      32'(exp_abt));
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // 5: stray bits in IDLE, then F0/swap 1 with invalid gap cycles carrying frame_start=1
        drive_bit(1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b0);
        drive_bit(1'b1, 1'b1, 1'b0);
        fr = {8'hF0, 1'b1, 1'b1};
        exp_q.push_back({1'b1, 8'hF0});
        for (int i = 0; i < 10; i++) begin
            repeat (gaps[i]) drive_bit(1'b0, 1'b1, 1'b1);
            drive_bit(1'b1, fr[9 - i], (i == 0));
        end
        check("t5_valid", 32'(out_valid), 32'd1);
        check("t5_swap",  32'(swap_out),  32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t5_drained", 32'(exp_q.size()), 32'd0);
        check("t5_abort",   32'(abt_cnt),      32'(exp_abt));

        // 6: async reset mid-frame with two entries held
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        send_frame(8'h11, 1'b0, even_par(8'h11, 1'b0));
        send_frame(8'h22, 1'b0, even_par(8'h22, 1'b0));
        drive_bit(1'b1, 1'b1, 1'b1);
        drive_bit(1'b1, 1'b1, 1'b0);
        drive_bit(1'b1, 1'b0, 1'b0);
        check("t6_valid_pre", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid_rst", 32'(out_valid), 32'd0);
        check("t6_data_rst",  32'(data_out),  32'd0);
        check("t6_swap_rst",  32'(swap_out),  32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back({1'b0, 8'h5A});
        send_frame(8'h5A, 1'b0, 1'b0);
        check("t6_valid", 32'(out_valid), 32'd1);
        check("t6_data",  32'(data_out),  32'h5A);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("final_drained", 32'(exp_q.size()), 32'd0);
        check("final_valid",   32'(out_valid),     32'd0);
        check("final_perr",    32'(perr_cnt),      32'(exp_perr));
        check("final_ovf",     32'(ovf_cnt),       32'(exp_ovf));
        check("final_abort",   32'(abt_cnt),       32'(exp_abt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_byte_deserializer.md
Name: serial_byte_deserializer

Overview:
- Upstream stage of the nibble-swap datapath: converts a framed serial bit stream into bytes, each paired with a per-byte swap request.
- Each byte and its swap flag are buffered in a small FIFO and presented on a valid/ready interface.
- The downstream swapper consumes data_out as its data_in and swap_out as its swap input.

Parameters:
- FIFO_DEPTH, 4, number of {swap,byte} entries buffered; power of two, minimum 2.
- PARITY_EN, 1, 1 = frame carries a trailing even-parity bit that is checked; 0 = no parity bit.

Ports:
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  asynchronous active-low reset
- sin_valid  input  1  sin_bit and frame_start are sampled this cycle
- sin_bit  input  1  serial data bit
- frame_start  input  1  qualified by sin_valid; marks the current bit as the first bit of a frame
- out_valid  output  1  FIFO head entry is valid
- out_ready  input  1  downstream accepts the head entry
- data_out  output  8  head byte
- swap_out  output  1  head swap request
- parity_err  output  1  one-cycle pulse: frame dropped for bad parity
- overflow  output  1  one-cycle pulse: frame dropped because the FIFO is full
- frame_abort  output  1  one-cycle pulse: partial frame discarded by a new frame_start

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to IDLE; bit counter and shift register clear; FIFO empties.
  - Outputs: out_valid=0, data_out=0, swap_out=0, parity_err=0, overflow=0, frame_abort=0.
- Frame format, bits taken only on cycles with sin_valid=1:
  - 8 data bits, MSB first (first bit is data[7]);
  - then 1 swap bit;
  - then 1 parity bit, only when PARITY_EN=1.
  - Even parity: XOR of the 8 data bits, the swap bit and the parity bit must equal 0.
- FSM states: IDLE, DATA, SWAP, PAR.
  - IDLE: sin_valid & ~frame_start bits are ignored. sin_valid & frame_start: the bit is stored as data[7], counter=1, go to DATA.
  - DATA: each valid bit shifts in. After the 8th data bit, go to SWAP.
  - SWAP: the valid bit is latched as the swap flag. If PARITY_EN=1, go to PAR. Otherwise the frame completes and the FSM goes to IDLE.
  - PAR: the valid bit is checked and the frame completes. Go to IDLE.
  - Gaps: sin_valid=0 cycles hold state in every state; there is no timeout.
- Abort: sin_valid & frame_start in DATA, SWAP or PAR:
  - the partial frame is discarded and frame_abort pulses the next cycle;
  - the bit is taken as the new data[7], counter=1, and the FSM goes to DATA.
- Frame completion, on the clock edge that samples the final bit:
  - Parity bad: no push; parity_err=1 for one cycle after that edge.
  - Parity good, FIFO not full, or full with a pop on the same edge: {swap,byte} is pushed. out_valid is 1 in the cycle after the edge (1-cycle latency from the final bit).
  - Parity good, FIFO full and no pop that edge: frame dropped; overflow=1 for one cycle. FIFO contents are unchanged.
- Output handshake:
  - A pop occurs on any edge with out_valid & out_ready.
  - data_out and swap_out are stable while out_valid=1 and out_ready=0.
  - When empty: out_valid=0, and data_out/swap_out hold their last value (0 after reset).
  - Simultaneous push and pop when empty: cannot happen, since out_valid=0. The push proceeds normally.
  - Simultaneous push and pop otherwise: both occur; the count is unchanged.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. A count (or extra pointer bit) distinguishes full from empty.
- Throughput: one bit per cycle maximum. A new frame_start may arrive on the cycle immediately after the final bit of the previous frame.
- Error pulses are never sticky and may coincide with out_valid activity. At most one of parity_err, overflow or frame_abort asserts per cycle.

Test Plan:
1. After reset, with PARITY_EN=1 and out_ready=1, send frame bits 1,0,1,0,0,1,0,1, swap 1, parity 1 -> one cycle later out_valid=1, data_out=8'hA5, swap_out=1. parity_err=0.
2. Same frame with parity bit 0 -> no push, parity_err pulses exactly once, out_valid stays 0.
3. With out_ready=0 and FIFO_DEPTH=4, send 5 good frames (bytes 8'h01..8'h05, swap=0) -> overflow pulses on the 5th. Then raise out_ready -> data_out sequence 01,02,03,04, then out_valid=0.
4. Send 4 data bits of a frame, then frame_start with a full new frame encoding 8'h3C, swap 0 -> frame_abort pulses once. Only 8'h3C is output.
5. Insert random sin_valid=0 gaps inside a frame encoding 8'hF0, swap 1 -> output 8'hF0, swap_out=1. Identical to the gap-free result.
6. Assert rst_n=0 mid-frame while the FIFO holds 2 entries -> out_valid drops immediately (asynchronous). After release, a fresh frame is output alone and correctly.
